// File: rtl/mem_ctrl.sv
// mem_ctrl: request/response sequencer in front of a 64x4 level-sensitive memory.
// Each beat runs SETUP (pins driven, en low) -> ACCESS (en rises) -> CAPTURE
// (en held), then RESP for reads. Memory pins only change while mem_en is low.
// Optional feature macro: MEM_CTRL_BURST_EN (honour req_len, 1-4 beats).
module mem_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_datain_q, mem_datain_d;
  logic               more_beats;

`ifdef MEM_CTRL_BURST_EN
  logic [1:0]         cnt_q, cnt_d;

  // Beats remaining after the current one
  assign more_beats = (cnt_q != 2'd0);
`else
  logic [1:0]         unused_len;

  // Single-beat build: the length field has no effect
  assign more_beats = 1'b0;
  assign unused_len = req_len;
`endif

  // Next-state and next-output logic; mem_rw/addr/datain double as the request latch
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_last_d   = rsp_last_q;
    mem_en_d     = mem_en_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
`ifdef MEM_CTRL_BURST_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        if (req_valid && req_ready_q) begin
          mem_rw_d     = !req_we;
          mem_addr_d   = req_addr;
          mem_datain_d = req_wdata;
`ifdef MEM_CTRL_BURST_EN
          cnt_d        = req_len;
`endif
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        mem_en_d = 1'b1;
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        mem_en_d = 1'b0;
        if (mem_rw_q) begin
          rsp_data_d  = mem_dataout;
          rsp_valid_d = 1'b1;
          rsp_last_d  = !more_beats;
          state_d     = S_RESP;
        end else if (more_beats) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
`ifdef MEM_CTRL_BURST_EN
          cnt_d      = cnt_q - 2'd1;
`endif
          state_d    = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        mem_en_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (more_beats) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
`ifdef MEM_CTRL_BURST_EN
            cnt_d      = cnt_q - 2'd1;
`endif
            state_d    = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        mem_en_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_last_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
`ifdef MEM_CTRL_BURST_EN
      cnt_q        <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_last_q   <= rsp_last_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
`ifdef MEM_CTRL_BURST_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign mem_en     = mem_en_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural 64x4 memory, scoreboard of expected read beats,
// monitor on response handshakes and memory-pin stability.
module tb_mem_ctrl;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 4;
`ifdef MEM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  logic [DATA_W-1:0] mem     [64];
  logic [DATA_W-1:0] ref_mem [64];
  exp_t              exp_q [$];

  int n_chk = 0;
  int n_err = 0;
  int en_rises = 0;
  int exp_rises = 0;

  logic              prev_en = 1'b0;
  logic              prev_rw = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_din = '0;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level-sensitive memory: acts while en is high
  always @(mem_en or mem_rw or mem_addr or mem_datain) begin
    if (mem_en) begin
      if (!mem_rw) mem[mem_addr] = mem_datain;
      else         mem_dataout   = mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response scoreboard and memory-pin protocol monitor
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rsp_unexpected: got data=%0h last=%0b, required no response", rsp_data, rsp_last);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", int'(rsp_data), int'(e.data));
        chk("rsp_last", int'(rsp_last), int'(e.last));
      end
    end
    if (mem_en && prev_en) begin
      chk("mem_addr_stable",   int'(mem_addr),   int'(prev_addr));
      chk("mem_rw_stable",     int'(mem_rw),     int'(prev_rw));
      chk("mem_datain_stable", int'(mem_datain), int'(prev_din));
    end
    if (mem_en && !prev_en) en_rises++;
    prev_en   = mem_en;
    prev_rw   = mem_rw;
    prev_addr = mem_addr;
    prev_din  = mem_datain;
  end

  // Issue one request; returns 1 time unit after the accepting edge
  task automatic do_req(input bit we, input int a, input int d, input int len, input bit push);
    int beats;
    int n;
    logic [ADDR_W-1:0] aa;
    beats = BURST ? len + 1 : 1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = ADDR_W'(a);
    req_wdata = DATA_W'(d);
    req_len   = 2'(len);
    for (int b = 0; b < beats; b++) begin
      aa = ADDR_W'(a + b);
      if (we) ref_mem[aa] = DATA_W'(d);
      else if (push) exp_q.push_back('{data: ref_mem[aa], last: (b == beats - 1)});
    end
    exp_rises += beats;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem_dataout = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  int'(req_ready),  0);
    chk("rst_rsp_valid",  int'(rsp_valid),  0);
    chk("rst_rsp_data",   int'(rsp_data),   0);
    chk("rst_rsp_last",   int'(rsp_last),   0);
    chk("rst_mem_en",     int'(mem_en),     0);
    chk("rst_mem_rw",     int'(mem_rw),     0);
    chk("rst_mem_addr",   int'(mem_addr),   0);
    chk("rst_mem_datain", int'(mem_datain), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", int'(req_ready), 1);

    // Write 5 <- A, then read 5 and check cycle-by-cycle latency
    do_req(1'b1, 5, 4'hA, 0, 1'b1);
    wait_idle();
    do_req(1'b0, 5, 0, 0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat_rsp_valid_c%0d", c), int'(rsp_valid), (c == 4) ? 1 : 0);
      chk($sformatf("lat_mem_en_c%0d", c),    int'(mem_en),    (c == 2 || c == 3) ? 1 : 0);
      chk($sformatf("lat_req_ready_c%0d", c), int'(req_ready), 0);
    end
    chk("lat_rsp_data", int'(rsp_data), 4'hA);
    chk("lat_rsp_last", int'(rsp_last), 1);
    wait_idle();

    // Backpressure: response held with en low until rsp_ready rises
    do_req(1'b1, 9, 4'h6, 0, 1'b1);
    wait_idle();
    rsp_ready = 1'b0;
    do_req(1'b0, 9, 0, 0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_data",  int'(rsp_data),  4'h6);
      chk("bp_rsp_last",  int'(rsp_last),  1);
      chk("bp_mem_en",    int'(mem_en),    0);
      chk("bp_req_ready", int'(req_ready), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_rsp_valid", int'(rsp_valid), 0);
    chk("bp_done_req_ready", int'(req_ready), 1);

    // Burst with address wrap 62,63,0,1
    if (BURST) begin
      do_req(1'b1, 62, 4'h3, 3, 1'b1);
      wait_idle();
      chk("burst_mem62", int'(mem[62]), 3);
      chk("burst_mem63", int'(mem[63]), 3);
      chk("burst_mem0",  int'(mem[0]),  3);
      chk("burst_mem1",  int'(mem[1]),  3);
      do_req(1'b0, 62, 0, 3, 1'b1);
      wait_idle();
    end

    // Reset during ACCESS of a read: no response may follow
    do_req(1'b0, 5, 0, 0, 1'b0);
    exp_rises = exp_rises - (BURST ? 1 : 1) + 1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_access", int'(mem_en), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_en",    int'(mem_en),    0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_req_ready", int'(req_ready), 1);
    repeat (8) @(posedge clk);
    #1;

    // Random traffic for pin-protocol coverage
    for (int r = 0; r < 100; r++) begin
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
      wait_idle();
    end
    repeat (4) @(posedge clk);
    #1;

    chk("rsp_outstanding", exp_q.size(), 0);
    chk("mem_en_rises", en_rises, exp_rises);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
